// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes and constant encodings,
// parametrised by exponent/fraction width for the multiplier, adder and divider.
package fp_pkg;

  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fp_class_t;

  // Encodings are built in the widest supported word and truncated by the caller.
  localparam int FP_MAX_W = 64;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic fp_word_t fp_exp_ones(input int exp_w, input int man_w);
    return ((fp_word_t'(1) << exp_w) - fp_word_t'(1)) << man_w;
  endfunction

  function automatic fp_word_t fp_qnan(input int exp_w, input int man_w);
    return fp_exp_ones(exp_w, man_w) | (fp_word_t'(1) << (man_w - 1));
  endfunction

  function automatic fp_word_t fp_inf(input logic sign, input int exp_w, input int man_w);
    return fp_exp_ones(exp_w, man_w) | (fp_word_t'(sign) << (exp_w + man_w));
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle of the pipelined FP multiplier.
interface fp_mult_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         invalid;
  logic         inexact;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, invalid, inexact
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow, invalid, inexact
  );
endinterface

// File: rtl/fp_unpack.sv
// Combinational operand unpack: class, sign, biased exponent and mantissa with
// hidden bit. Subnormals are flushed to zero of the same sign.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     biased_exp,
  output logic [MAN_W:0]       man
);

  logic [MAN_W-1:0] frac;

  assign sign       = x[EXP_W+MAN_W];
  assign biased_exp = x[EXP_W+MAN_W-1 -: EXP_W];
  assign frac       = x[MAN_W-1:0];

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cls = NORMAL;
    man = {1'b1, frac};
    if (biased_exp == '0) begin
      cls = ZERO;
      man = '0;
    end else if (&biased_exp) begin
      if (frac == '0)          cls = INF;
      else if (frac[MAN_W-1])  cls = QNAN;
      else                     cls = SNAN;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-style FP multiplier (RNE, flush-to-zero) with a global
// valid/ready stall: S1 classify/multiply, S2 normalise/round, S3 range/mux.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic           clk,
  input logic           rst_n,
  fp_mult_pipe_if.slave bus
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int P   = 2 * MAN_W + 2;
  localparam int E_W = EXP_W + 2;

  typedef logic signed [E_W-1:0] exp_t;

  typedef struct packed {
    logic         special;
    logic         invalid;
    logic [W-1:0] res;
  } special_t;

  localparam exp_t         BIAS    = exp_t'(fp_bias(EXP_W));
  localparam exp_t         EXP_MAX = exp_t'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN_W  = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0] INF_W   = W'(fp_inf(1'b0, EXP_W, MAN_W));

  logic advance;
  logic v1, v2, out_valid_q;
  logic [W-1:0] result_q;
  logic overflow_q, underflow_q, invalid_q, inexact_q;

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.invalid   = invalid_q;
  assign bus.inexact   = inexact_q;

  // ---------------- S1: classify, exponent sum, multiply ----------------
  fp_class_t        cls_a, cls_b;
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   man_a, man_b;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(bus.a), .cls(cls_a), .sign(sign_a), .biased_exp(exp_a), .man(man_a)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(bus.b), .cls(cls_b), .sign(sign_b), .biased_exp(exp_b), .man(man_b)
  );

  logic         s1_sign_n;
  exp_t         s1_exp_n;
  logic [P-1:0] s1_prod_n;
  special_t     s1_spec_n;

  assign s1_sign_n = sign_a ^ sign_b;
  assign s1_exp_n  = exp_t'({2'b00, exp_a}) + exp_t'({2'b00, exp_b}) - BIAS;
  assign s1_prod_n = P'(man_a) * P'(man_b);

  always_comb begin
    s1_spec_n.special = (cls_a != NORMAL) || (cls_b != NORMAL);
    s1_spec_n.invalid = 1'b0;
    s1_spec_n.res     = QNAN_W;
    if (cls_a inside {QNAN, SNAN} || cls_b inside {QNAN, SNAN}) begin
      s1_spec_n.invalid = (cls_a == SNAN) || (cls_b == SNAN);
    end else if ((cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO)) begin
      s1_spec_n.invalid = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      s1_spec_n.res = {s1_sign_n, INF_W[W-2:0]};
    end else begin
      s1_spec_n.res = {s1_sign_n, {(W-1){1'b0}}};
    end
  end

  logic         s1_sign;
  exp_t         s1_exp;
  logic [P-1:0] s1_prod;
  special_t     s1_spec;

  // ---------------- S2: normalise, round to nearest even ----------------
  logic [P-1:0]     norm;
  logic [MAN_W:0]   mant;
  logic             guard, sticky, lsb;
  logic [MAN_W+1:0] rnd;
  exp_t             s2_exp_n;

  assign norm   = s1_prod[P-1] ? s1_prod : (s1_prod << 1);
  assign mant   = norm[P-1 -: MAN_W+1];
  assign lsb    = norm[MAN_W+1];
  assign guard  = norm[MAN_W];
  assign sticky = |norm[MAN_W-1:0];
  assign rnd    = {1'b0, mant} + (MAN_W+2)'(guard & (sticky | lsb));
  // A rounding carry leaves rnd = 10.0...0, so its fraction bits are already zero.
  assign s2_exp_n = s1_exp + exp_t'({{(E_W-1){1'b0}}, s1_prod[P-1]})
                           + exp_t'({{(E_W-1){1'b0}}, rnd[MAN_W+1]});

  logic             s2_sign;
  exp_t             s2_exp;
  logic [MAN_W-1:0] s2_frac;
  logic             s2_inexact;
  special_t         s2_spec;

  // ---------------- S3: range check, final mux ----------------
  logic [W-1:0] res_n;
  logic         ovf_n, unf_n, inv_n, inx_n;

  always_comb begin
    res_n = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inv_n = 1'b0;
    inx_n = s2_inexact;
    if (s2_spec.special) begin
      res_n = s2_spec.res;
      inv_n = s2_spec.invalid;
      inx_n = 1'b0;
    end else if (!s2_exp[E_W-1] && s2_exp >= EXP_MAX) begin
      res_n = {s2_sign, INF_W[W-2:0]};
      ovf_n = 1'b1;
      inx_n = 1'b1;
    end else if (s2_exp[E_W-1] || s2_exp == '0) begin
      res_n = {s2_sign, {(W-1){1'b0}}};
      unf_n = 1'b1;
      inx_n = 1'b1;
    end
  end

  // ---------------- Registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
    end else if (advance) begin
      v1          <= bus.in_valid;
      v2          <= v1;
      out_valid_q <= v2;
      result_q    <= res_n;
      overflow_q  <= ovf_n;
      underflow_q <= unf_n;
      invalid_q   <= inv_n;
      inexact_q   <= inx_n;
    end
  end

  // NOTE: internal datapath registers are qualified by the stage valids, so
  // they carry no reset; mixing them into the reset block would turn rst_n
  // into a hold-enable on them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign    <= s1_sign_n;
      s1_exp     <= s1_exp_n;
      s1_prod    <= s1_prod_n;
      s1_spec    <= s1_spec_n;
      s2_sign    <= s1_sign;
      s2_exp     <= s2_exp_n;
      s2_frac    <= rnd[MAN_W-1:0];
      s2_inexact <= guard | sticky;
      s2_spec    <= s1_spec;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: single- and double-precision instances,
// special cases, rounding, range flags, back-pressure and mid-stream reset.
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fp_mult_pipe_if #(.W(32)) sp_bus ();
  fp_mult_pipe_if #(.W(64)) dp_bus ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (
    .clk(clk), .rst_n(rst_n), .bus(sp_bus.slave)
  );
  fp_mult_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (
    .clk(clk), .rst_n(rst_n), .bus(dp_bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sp_flags();
    return {sp_bus.overflow, sp_bus.underflow, sp_bus.invalid, sp_bus.inexact};
  endfunction

  // Flags vector order: {overflow, underflow, invalid, inexact}.
  task automatic sp_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input logic [3:0] exp_flags);
    @(negedge clk);
    sp_bus.in_valid  = 1'b1;
    sp_bus.a         = x;
    sp_bus.b         = y;
    sp_bus.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(sp_bus.in_ready), 64'd1);
    @(negedge clk);
    sp_bus.in_valid = 1'b0;
    for (int i = 0; i < 8 && !sp_bus.out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 64'(sp_bus.out_valid), 64'd1);
    check({tag, "_res"}, 64'(sp_bus.result), 64'(exp_res));
    check({tag, "_flags"}, 64'(sp_flags()), 64'(exp_flags));
  endtask

  task automatic dp_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp_res, input logic [3:0] exp_flags);
    @(negedge clk);
    dp_bus.in_valid  = 1'b1;
    dp_bus.a         = x;
    dp_bus.b         = y;
    dp_bus.out_ready = 1'b1;
    @(negedge clk);
    dp_bus.in_valid = 1'b0;
    for (int i = 0; i < 8 && !dp_bus.out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 64'(dp_bus.out_valid), 64'd1);
    check({tag, "_res"}, dp_bus.result, exp_res);
    check({tag, "_flags"},
          64'({dp_bus.overflow, dp_bus.underflow, dp_bus.invalid, dp_bus.inexact}),
          64'(exp_flags));
  endtask

  logic [31:0] bp_a   [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] bp_exp [5] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};
  int accepted;
  int received;

  initial begin
    rst_n            = 1'b0;
    sp_bus.in_valid  = 1'b0;
    sp_bus.a         = '0;
    sp_bus.b         = '0;
    sp_bus.out_ready = 1'b1;
    dp_bus.in_valid  = 1'b0;
    dp_bus.a         = '0;
    dp_bus.b         = '0;
    dp_bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(sp_bus.out_valid), 64'd0);
    check("rst_result", 64'(sp_bus.result), 64'd0);
    check("rst_flags", 64'(sp_flags()), 64'd0);
    check("rst_in_ready", 64'(sp_bus.in_ready), 64'd1);
    rst_n = 1'b1;

    // 2 x 3 accepted in the first cycle after reset, with exact latency
    sp_bus.in_valid = 1'b1;
    sp_bus.a        = 32'h40000000;
    sp_bus.b        = 32'h40400000;
    @(negedge clk);
    sp_bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", 64'(sp_bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(sp_bus.out_valid), 64'd1);
    check("lat_res", 64'(sp_bus.result), 64'h40C00000);
    check("lat_flags", 64'(sp_flags()), 64'd0);
    @(negedge clk);
    check("lat_single", 64'(sp_bus.out_valid), 64'd0);

    sp_op("rne_up",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    sp_op("tie_odd",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    sp_op("tie_even",   32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
    sp_op("rnd_carry",  32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001);
    sp_op("overflow",   32'h7F000000, 32'h40000000, 32'h7F800000, 4'b1001);
    sp_op("underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 4'b0101);
    sp_op("zero_inf",   32'h80000000, 32'h7F800000, 32'h7FC00000, 4'b0010);
    sp_op("snan",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0010);
    sp_op("qnan",       32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
    sp_op("inf_norm",   32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
    sp_op("neg_zero",   32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    sp_op("subn_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);

    // Back-pressure: five ops with the consumer stalled
    accepted = 0;
    received = 0;
    @(negedge clk);
    sp_bus.out_ready = 1'b0;
    sp_bus.b         = 32'h40000000;
    repeat (6) begin
      sp_bus.in_valid = (accepted < 5);
      sp_bus.a        = (accepted < 5) ? bp_a[accepted] : 32'h0;
      #1 if (sp_bus.in_valid && sp_bus.in_ready) accepted++;
      @(negedge clk);
    end
    check("bp_accepts", 64'(accepted), 64'd3);
    check("bp_in_ready", 64'(sp_bus.in_ready), 64'd0);
    check("bp_hold_valid", 64'(sp_bus.out_valid), 64'd1);
    check("bp_hold_res", 64'(sp_bus.result), 64'(bp_exp[0]));
    repeat (2) @(negedge clk);
    check("bp_stable_res", 64'(sp_bus.result), 64'(bp_exp[0]));

    sp_bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && received < 5; cyc++) begin
      sp_bus.in_valid = (accepted < 5);
      sp_bus.a        = (accepted < 5) ? bp_a[accepted] : 32'h0;
      #1;
      if (sp_bus.in_valid && sp_bus.in_ready) accepted++;
      if (sp_bus.out_valid) begin
        check($sformatf("bp_order_%0d", received), 64'(sp_bus.result), 64'(bp_exp[received]));
        received++;
      end
      @(negedge clk);
    end
    sp_bus.in_valid = 1'b0;
    check("bp_received", 64'(received), 64'd5);
    check("bp_all_accepted", 64'(accepted), 64'd5);
    repeat (3) @(negedge clk);
    check("bp_no_dup", 64'(sp_bus.out_valid), 64'd0);

    // Asynchronous reset with an overflow result held at the output
    sp_bus.out_ready = 1'b0;
    sp_bus.in_valid  = 1'b1;
    sp_bus.a         = 32'h7F000000;
    sp_bus.b         = 32'h40000000;
    @(negedge clk);
    sp_bus.a = 32'h40000000;
    for (int i = 0; i < 8 && !sp_bus.out_valid; i++) @(negedge clk);
    check("mid_pre_valid", 64'(sp_bus.out_valid), 64'd1);
    check("mid_pre_ovf", 64'(sp_bus.overflow), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(sp_bus.out_valid), 64'd0);
    check("mid_rst_res", 64'(sp_bus.result), 64'd0);
    check("mid_rst_flags", 64'(sp_flags()), 64'd0);
    check("mid_rst_in_ready", 64'(sp_bus.in_ready), 64'd1);
    @(negedge clk);
    sp_bus.in_valid  = 1'b0;
    sp_bus.out_ready = 1'b1;
    rst_n            = 1'b1;
    received         = 0;
    repeat (5) begin
      @(negedge clk);
      if (sp_bus.out_valid) received++;
    end
    check("mid_discarded", 64'(received), 64'd0);

    // Double precision
    dp_op("dp_2x3",  64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 4'b0000);
    dp_op("dp_snan", 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 4'b0010);
    dp_op("dp_ovf",  64'h7FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 4'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined floating-point multiplier for the FPU datapath, the successor of the single-cycle single-precision multiplier. Generic exponent/mantissa widths (single by default, double by parameter), three register stages with valid/ready flow control, round-to-nearest-even, signed zero, and a full IEEE-style flag set (overflow, underflow, invalid, inexact). It sits between the FPU issue logic and the FP writeback mux.

## Interface
- `EXP_W`, 8: exponent field width.
- `MAN_W`, 23: stored fraction width (hidden bit excluded); word width `W = 1+EXP_W+MAN_W`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`/`b` present.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`, `b`  in  W  operands, IEEE layout {sign, exp, frac}.
- `out_valid`  out  1  `result`/flags valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  W  product.
- `overflow`, `underflow`, `invalid`, `inexact`  out  1 each  flags qualified by `out_valid`.

## Operation
- Classification per operand:
  - zero: exp=0; subnormals are flushed to zero, same sign.
  - inf: exp all-ones, frac=0.
  - qNaN: exp all-ones, frac MSB=1.
  - sNaN: exp all-ones, frac MSB=0, frac≠0.
  - normal: everything else.
- Special cases, priority order:
  - any NaN → canonical qNaN {0, all-ones, 1, 0…}; `invalid`=1 if either operand is an sNaN.
  - zero×inf → canonical qNaN, `invalid`=1.
  - inf×(inf|normal) → ±inf, sign = sa^sb.
  - zero×(zero|normal) → ±0, sign = sa^sb.
  - No flags other than `invalid` are raised on special results.
- Normal path:
  - Sign = sa^sb.
  - Exponent = ea+eb−BIAS in signed EXP_W+2 bits, BIAS = 2^(EXP_W−1)−1.
  - Product of (MAN_W+1)-bit mantissas is 2·MAN_W+2 bits. If the top bit is set, shift right 1 and exp+1.
  - Round-to-nearest-even using guard bit and sticky (OR of remaining bits). Round-up carry out of the mantissa → mantissa 1.0, exp+1.
  - `inexact` = guard|sticky.
- Range check after rounding:
  - exp ≥ 2^EXP_W−1 → ±inf, `overflow`=1, `inexact`=1.
  - exp ≤ 0 → ±0 (flush), `underflow`=1, `inexact`=1.

## Timing
- Latency 3 cycles accept→`out_valid`:
  - S1: classify, exp sum, multiply.
  - S2: normalise, round.
  - S3: range check, final mux, output registers.
- Throughput: one operation per cycle.
- Global stall: `advance = !out_valid | out_ready`; `in_ready = advance`.
  - When `advance`=0, every stage holds its contents.
  - Bubbles are carried as valid=0 and are not compressed.
- Transfer rules: accept on `in_valid & in_ready`; output transfer on `out_valid & out_ready`.
- Simultaneous accept and output in the same cycle is legal and loses nothing.
- `result` and flags stay stable while `out_valid & !out_ready`.
- Reset (asynchronous, any time, including mid-pipeline): all stage valids, `out_valid`, `result` and all flags go to 0; in-flight operations are discarded.
- First accept is possible in the first cycle after `rst_n` deasserts.

## Structure
- Shared package `fp_pkg`:
  - `fp_class_t` enum {ZERO, NORMAL, INF, QNAN, SNAN}.
  - Functions for bias, canonical qNaN and ±inf, all parametrised by EXP_W/MAN_W.
  - Reused by the future adder/divider.
- Sub-module `fp_unpack`: combinational; per-operand class, sign, exp, mantissa with hidden bit. Instantiated twice in S1.
- Pipeline registers and the handshake live in the top module.

## Test plan
- 0x40000000 × 0x40400000 (2×3) → 0x40C00000 after 3 cycles, all flags 0.
- 0x3F800001 × 0x3F800001 → 0x3F800002 (RNE), `inexact`=1.
- 0x7F000000 × 0x40000000 → 0x7F800000, `overflow`=1, `inexact`=1.
- 0x00800000 × 0x3F000000 → 0x00000000, `underflow`=1.
- Invalid operations:
  - 0x80000000 × 0x7F800000 → 0x7FC00000, `invalid`=1.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, `invalid`=1.
- Back-pressure:
  - Stream 5 ops with `out_ready`=0 → `in_ready` drops after 3 accepts.
  - Release `out_ready` → all 5 results delivered in order, none lost or duplicated.
  - Assert `rst_n`=0 mid-stream → outputs 0 immediately.
- Double precision (`EXP_W`=11, `MAN_W`=52): 0x4000000000000000 × 0x4008000000000000 → 0x4018000000000000.
